// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU, the combinational ALU and the
// bench model: opcode encodings, flag bundle layout and FSM state type.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_ADC = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_INC = 4'd4;
    localparam logic [3:0] OP_DEC = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_ROR = 4'd9;
    localparam logic [3:0] OP_OR  = 4'd10;
    localparam logic [3:0] OP_XOR = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12;

    typedef struct packed {
        logic invalid_op;
        logic parity;
        logic zero;
        logic borrow;
        logic carry_out;
    } alu_flags_t;

    typedef enum logic {
        ST_IDLE,
        ST_MUL_RUN
    } alu_state_t;

    // Ops whose carry/borrow result is kept in the internal carry flag.
    function automatic logic sets_carry_flag(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_ADC) || (op == OP_INC) ||
               (op == OP_SUB) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe.
//   master: operand source + result sink (drives in_valid, opcode, a, b,
//           carry_in, out_ready)
//   slave : the ALU (drives in_ready, out_valid, y, y_hi, flags, busy)
interface alu_pipe_if #(
    parameter int BUS_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           opcode;
    logic [BUS_WIDTH-1:0] a;
    logic [BUS_WIDTH-1:0] b;
    logic                 carry_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [BUS_WIDTH-1:0] y;
    logic [BUS_WIDTH-1:0] y_hi;
    logic                 carry_out;
    logic                 borrow;
    logic                 zero;
    logic                 parity;
    logic                 invalid_op;
    logic                 busy;

    modport master (
        output in_valid, opcode, a, b, carry_in, out_ready,
        input  in_ready, out_valid, y, y_hi, carry_out, borrow, zero,
               parity, invalid_op, busy
    );

    modport slave (
        input  in_valid, opcode, a, b, carry_in, out_ready,
        output in_ready, out_valid, y, y_hi, carry_out, borrow, zero,
               parity, invalid_op, busy
    );
endinterface

// File: rtl/alu_mul_shiftadd.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
//   clk, rst_n : clock, async active-low reset
//   start      : load a/b and begin (ignored while running)
//   a, b       : multiplicand, multiplier
//   busy       : iterations still in progress
//   done       : product valid; held for exactly one cycle, then idles
//   product    : 2*BUS_WIDTH-bit result
module alu_mul_shiftadd #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [BUS_WIDTH-1:0]   a,
    input  logic [BUS_WIDTH-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [2*BUS_WIDTH-1:0] product
);
    localparam int            CW   = $clog2(BUS_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(BUS_WIDTH);

    logic [BUS_WIDTH-1:0] mcand;
    logic [BUS_WIDTH-1:0] acc_hi;
    logic [BUS_WIDTH-1:0] acc_lo;
    logic [CW-1:0]        cnt;
    logic                 run;
    logic [BUS_WIDTH:0]   sum;

    // acc_lo starts as the multiplier and is shifted out LSB first while the
    // product's low half is shifted in from the top.
    always_comb begin
        sum = {1'b0, acc_hi};
        if (acc_lo[0]) sum = {1'b0, acc_hi} + {1'b0, mcand};
    end

    assign busy    = run && (cnt != LAST);
    assign done    = run && (cnt == LAST);
    assign product = {acc_hi, acc_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (start && !run) begin
            mcand  <= a;
            acc_hi <= '0;
            acc_lo <= b;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (busy) begin
            acc_hi <= sum[BUS_WIDTH:1];
            acc_lo <= {sum[0], acc_lo[BUS_WIDTH-1:1]};
            cnt    <= cnt + CW'(1);
        end else if (done) begin
            run    <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_pipe.sv
// Registered, handshaked ALU with an iterative multiply.
//   clk, rst_n : clock, async active-low reset
//   bus        : alu_pipe_if slave (operand in, result out, flags, busy)
// Parameters: BUS_WIDTH (>=2); CARRY_FROM_FLAG selects the ADC carry source
// (0: bus.carry_in, 1: internal carry flag).
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | accepting ops; single-cycle results load on accept
//   ST_MUL_RUN | multiplier iterating; result loads when it reports done
module alu_pipe
    import alu_pkg::*;
#(
    parameter int BUS_WIDTH       = 8,
    parameter bit CARRY_FROM_FLAG = 1'b0
) (
    input logic       clk,
    input logic       rst_n,
    alu_pipe_if.slave bus
);
    alu_state_t             state_q, state_d;
    logic                   out_valid_q;
    logic [BUS_WIDTH-1:0]   y_q, y_hi_q;
    alu_flags_t             flags_q;
    logic                   carry_flag_q;

    logic                   in_ready;
    logic                   accept;
    logic                   mul_start, load_single, load_mul;
    logic                   mul_busy, mul_done;
    logic [2*BUS_WIDTH-1:0] product;

    logic                   c_in;
    logic [BUS_WIDTH:0]     wide;
    alu_flags_t             res_flags, mul_flags;

    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign c_in     = CARRY_FROM_FLAG ? carry_flag_q : bus.carry_in;

    always_comb begin
        state_d     = state_q;
        mul_start   = 1'b0;
        load_single = 1'b0;
        load_mul    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.opcode == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = ST_MUL_RUN;
                    end else begin
                        load_single = 1'b1;
                    end
                end
            end
            ST_MUL_RUN: begin
                if (mul_done) begin
                    load_mul = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Single-cycle datapath; the MSB of 'wide' is the carry or borrow.
    always_comb begin
        wide      = '0;
        res_flags = '0;
        case (bus.opcode)
            OP_ADD: wide = {1'b0, bus.a} + {1'b0, bus.b};
            OP_ADC: wide = {1'b0, bus.a} + {1'b0, bus.b} + {{BUS_WIDTH{1'b0}}, c_in};
            OP_SUB: wide = {1'b0, bus.a} - {1'b0, bus.b};
            OP_INC: wide = {1'b0, bus.a} + {{BUS_WIDTH{1'b0}}, 1'b1};
            OP_DEC: wide = {1'b0, bus.a} - {{BUS_WIDTH{1'b0}}, 1'b1};
            OP_AND: wide = {1'b0, bus.a & bus.b};
            OP_NOT: wide = {1'b0, ~bus.a};
            OP_ROL: wide = {1'b0, bus.a[BUS_WIDTH-2:0], bus.a[BUS_WIDTH-1]};
            OP_ROR: wide = {1'b0, bus.a[0], bus.a[BUS_WIDTH-1:1]};
            OP_OR:  wide = {1'b0, bus.a | bus.b};
            OP_XOR: wide = {1'b0, bus.a ^ bus.b};
            default: res_flags.invalid_op = 1'b1;
        endcase
        case (bus.opcode)
            OP_ADD, OP_ADC, OP_INC: res_flags.carry_out = wide[BUS_WIDTH];
            OP_SUB, OP_DEC:         res_flags.borrow    = wide[BUS_WIDTH];
            default: ;
        endcase
        if (!res_flags.invalid_op) begin
            res_flags.zero   = (wide[BUS_WIDTH-1:0] == '0);
            res_flags.parity = ^wide[BUS_WIDTH-1:0];
        end
    end

    always_comb begin
        mul_flags        = '0;
        mul_flags.zero   = (product == '0);
        mul_flags.parity = ^product;
    end

    alu_mul_shiftadd #(.BUS_WIDTH(BUS_WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b0;
            y_q          <= '0;
            y_hi_q       <= '0;
            flags_q      <= '0;
            carry_flag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_single) begin
                y_q         <= wide[BUS_WIDTH-1:0];
                y_hi_q      <= '0;
                flags_q     <= res_flags;
                out_valid_q <= 1'b1;
                if (sets_carry_flag(bus.opcode))
                    carry_flag_q <= res_flags.carry_out | res_flags.borrow;
            end else if (load_mul) begin
                y_q         <= product[BUS_WIDTH-1:0];
                y_hi_q      <= product[2*BUS_WIDTH-1:BUS_WIDTH];
                flags_q     <= mul_flags;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.y          = y_q;
    assign bus.y_hi       = y_hi_q;
    assign bus.carry_out  = flags_q.carry_out;
    assign bus.borrow     = flags_q.borrow;
    assign bus.zero       = flags_q.zero;
    assign bus.parity     = flags_q.parity;
    assign bus.invalid_op = flags_q.invalid_op;
    assign bus.busy       = mul_busy;
endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_pipe_if #(.BUS_WIDTH(W)) bus0 ();
    alu_pipe_if #(.BUS_WIDTH(W)) bus1 ();

    alu_pipe #(.BUS_WIDTH(W), .CARRY_FROM_FLAG(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    alu_pipe #(.BUS_WIDTH(W), .CARRY_FROM_FLAG(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    // Both instances see identical stimulus; only ADC's carry source differs.
    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.opcode    = bus0.opcode;
    assign bus1.a         = bus0.a;
    assign bus1.b         = bus0.b;
    assign bus1.carry_in  = bus0.carry_in;
    assign bus1.out_ready = bus0.out_ready;

    // {y_hi, y, invalid_op, parity, zero, borrow, carry_out}
    typedef struct packed {
        logic [7:0] y_hi;
        logic [7:0] y;
        logic [4:0] fl;
    } res_t;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] y;
        logic [7:0] y_hi;
        logic [4:0] fl;
    } vec_t;

    int   n_pass  = 0;
    int   n_total = 0;
    logic mflag1  = 1'b0;
    vec_t tv[$];
    res_t q0[$];
    res_t q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain integer arithmetic on the opcode meanings.
    function automatic res_t model(input int op, input int a, input int b, input int cin);
        res_t e;
        int   r, full;
        logic inv, cout, brw;
        e = '0; r = 0; inv = 1'b0;
        case (op)
            1:  r = a + b;
            2:  r = a + b + cin;
            3:  r = a - b;
            4:  r = a + 1;
            5:  r = a - 1;
            6:  r = a & b;
            7:  r = (~a) & 255;
            8:  r = ((a << 1) | (a >> 7)) & 255;
            9:  r = ((a >> 1) | (a << 7)) & 255;
            10: r = a | b;
            11: r = a ^ b;
            12: r = a * b;
            default: inv = 1'b1;
        endcase
        cout = (op == 1 || op == 2 || op == 4) && (r > 255);
        brw  = (op == 3 || op == 5) && (r < 0);
        full = (op == 12) ? r : (r & 255);
        e.y    = 8'(full & 255);
        e.y_hi = 8'((full >> 8) & 255);
        e.fl   = {inv, ($countones(full) % 2) == 1, !inv && (full == 0), brw, cout};
        return e;
    endfunction

    function automatic res_t act(input int d);
        if (d == 0)
            return {bus0.y_hi, bus0.y, bus0.invalid_op, bus0.parity, bus0.zero, bus0.borrow, bus0.carry_out};
        return {bus1.y_hi, bus1.y, bus1.invalid_op, bus1.parity, bus1.zero, bus1.borrow, bus1.carry_out};
    endfunction

    // Presents one op, waits (bounded) for acceptance, returns model results.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, output res_t e0, output res_t e1);
        int n = 0;
        bus0.opcode = op; bus0.a = a; bus0.b = b; bus0.carry_in = cin;
        bus0.in_valid = 1'b1;
        #1;
        while (!bus0.in_ready && n < 50) begin step(); n++; end
        if (n >= 50) check("accept_timeout", 32'(bus0.in_ready), 1);
        e0 = model(op, a, b, cin);
        e1 = model(op, a, b, (op == OP_ADC) ? mflag1 : cin);
        if (sets_carry_flag(op)) mflag1 = e1.fl[0] | e1.fl[1];
        step();
        bus0.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        while (!bus0.out_valid && n < 40) begin step(); n++; end
        check({name, "_out_valid"}, 32'(bus0.out_valid), 1);
    endtask

    initial begin
        res_t e0, e1;
        logic [3:0] rop;
        logic [7:0] ra, rb;
        logic       rcin, pending, bad;

        bus0.in_valid = 1'b0; bus0.opcode = '0; bus0.a = '0; bus0.b = '0;
        bus0.carry_in = 1'b0; bus0.out_ready = 1'b1;

        tv.push_back('{OP_ADD, 8'd200, 8'd100, 1'b0, 8'd44,  8'd0,   5'b01001});
        tv.push_back('{OP_ADD, 8'd0,   8'd0,   1'b0, 8'd0,   8'd0,   5'b00100});
        tv.push_back('{OP_ADC, 8'd10,  8'd20,  1'b1, 8'd31,  8'd0,   5'b01000});
        tv.push_back('{OP_SUB, 8'd7,   8'd5,   1'b0, 8'd2,   8'd0,   5'b01000});
        tv.push_back('{OP_SUB, 8'd5,   8'd7,   1'b0, 8'd254, 8'd0,   5'b01010});
        tv.push_back('{OP_INC, 8'd255, 8'd0,   1'b0, 8'd0,   8'd0,   5'b00101});
        tv.push_back('{OP_DEC, 8'd0,   8'd0,   1'b0, 8'd255, 8'd0,   5'b00010});
        tv.push_back('{OP_DEC, 8'd1,   8'd0,   1'b0, 8'd0,   8'd0,   5'b00100});
        tv.push_back('{OP_AND, 8'hFF,  8'h07,  1'b0, 8'h07,  8'd0,   5'b01000});
        tv.push_back('{OP_NOT, 8'h0F,  8'h00,  1'b0, 8'hF0,  8'd0,   5'b00000});
        tv.push_back('{OP_ROL, 8'h81,  8'h00,  1'b0, 8'h03,  8'd0,   5'b00000});
        tv.push_back('{OP_ROR, 8'h81,  8'h00,  1'b0, 8'hC0,  8'd0,   5'b00000});
        tv.push_back('{OP_ROL, 8'h80,  8'h00,  1'b0, 8'h01,  8'd0,   5'b01000});
        tv.push_back('{OP_OR,  8'h12,  8'h21,  1'b0, 8'h33,  8'd0,   5'b00000});
        tv.push_back('{OP_XOR, 8'hFF,  8'h0E,  1'b0, 8'hF1,  8'd0,   5'b01000});
        tv.push_back('{OP_MUL, 8'd255, 8'd255, 1'b0, 8'd1,   8'd254, 5'b00000});
        tv.push_back('{OP_MUL, 8'd0,   8'd7,   1'b0, 8'd0,   8'd0,   5'b00100});
        tv.push_back('{OP_MUL, 8'd16,  8'd16,  1'b0, 8'd0,   8'd1,   5'b01000});
        tv.push_back('{4'd0,   8'd9,   8'd9,   1'b0, 8'd0,   8'd0,   5'b10000});
        tv.push_back('{4'd15,  8'd3,   8'd4,   1'b0, 8'd0,   8'd0,   5'b10000});

        // Reset state
        #12;
        check("rst_out_valid", 32'(bus0.out_valid), 0);
        check("rst_res", 32'(act(0)), 0);
        check("rst_busy", 32'(bus0.busy), 0);
        check("rst_in_ready", 32'(bus0.in_ready), 1);
        rst_n = 1'b1;
        step();

        // Table vectors
        for (int i = 0; i < tv.size(); i++) begin
            issue(tv[i].op, tv[i].a, tv[i].b, tv[i].cin, e0, e1);
            wait_out($sformatf("tv%0d", i));
            check($sformatf("tv%0d_dut0", i), 32'(act(0)), 32'({tv[i].y_hi, tv[i].y, tv[i].fl}));
            check($sformatf("tv%0d_dut1", i), 32'(act(1)), 32'(e1));
            step();
        end

        // MUL latency and busy/in_ready window
        issue(OP_MUL, 8'd255, 8'd255, 1'b0, e0, e1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("mul_busy%0d", i), 32'({bus0.busy, bus0.in_ready, bus0.out_valid}), 32'b100);
            step();
        end
        check("mul_last_iter", 32'({bus0.busy, bus0.in_ready, bus0.out_valid}), 32'b000);
        step();
        check("mul_out_valid", 32'(bus0.out_valid), 1);
        check("mul_res", 32'(act(0)), 32'({8'd254, 8'd1, 5'b00000}));
        step();
        check("mul_consumed", 32'(bus0.out_valid), 0);

        // Back-to-back INC 255 then DEC 0
        bus0.opcode = OP_INC; bus0.a = 8'd255; bus0.b = 8'd0; bus0.in_valid = 1'b1;
        step();
        check("b2b_inc", 32'({bus0.out_valid, act(0)}), 32'({1'b1, 8'd0, 8'd0, 5'b00101}));
        check("b2b_ready1", 32'(bus0.in_ready), 1);
        bus0.opcode = OP_DEC; bus0.a = 8'd0;
        step();
        check("b2b_dec", 32'({bus0.out_valid, act(0)}), 32'({1'b1, 8'd0, 8'd255, 5'b00010}));
        check("b2b_ready2", 32'(bus0.in_ready), 1);
        bus0.in_valid = 1'b0;
        step();
        check("b2b_drain", 32'(bus0.out_valid), 0);
        mflag1 = 1'b1;

        // Backpressure hold
        bus0.out_ready = 1'b0;
        issue(OP_SUB, 8'd5, 8'd7, 1'b0, e0, e1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_hold%0d", i), 32'({bus0.out_valid, bus0.in_ready, act(0)}),
                  32'({1'b1, 1'b0, 8'd0, 8'd254, 5'b01010}));
            step();
        end
        bus0.out_ready = 1'b1;
        #1;
        check("bp_ready", 32'(bus0.in_ready), 1);
        step();
        check("bp_release", 32'(bus0.out_valid), 0);

        // Carry flag chaining (dut1 reads its internal flag for ADC)
        issue(OP_ADD, 8'd255, 8'd1, 1'b0, e0, e1); wait_out("cf_add"); step();
        issue(OP_ADC, 8'd0, 8'd0, 1'b0, e0, e1); wait_out("cf_adc");
        check("cf_adc_dut1", 32'(bus1.y), 1);
        check("cf_adc_dut0", 32'(bus0.y), 0);
        step();
        issue(OP_ADD, 8'd255, 8'd1, 1'b0, e0, e1); wait_out("cf_add2"); step();
        issue(4'd14, 8'd5, 8'd5, 1'b0, e0, e1); wait_out("cf_inv");
        check("cf_inv_res", 32'(act(1)), 32'({8'd0, 8'd0, 5'b10000}));
        step();
        issue(OP_ADC, 8'd0, 8'd0, 1'b0, e0, e1); wait_out("cf_adc2");
        check("cf_adc2_dut1", 32'(bus1.y), 1);
        step();

        // Reset in the middle of a MUL
        issue(OP_ADD, 8'd200, 8'd100, 1'b0, e0, e1); wait_out("rm_add"); step();
        issue(OP_MUL, 8'd3, 8'd5, 1'b0, e0, e1);
        step(); step();
        check("rm_busy_before", 32'(bus0.busy), 1);
        rst_n = 1'b0;
        #1;
        check("rm_res0", 32'({bus0.out_valid, bus0.busy, act(0)}), 0);
        check("rm_res1", 32'({bus1.out_valid, bus1.busy, act(1)}), 0);
        mflag1 = 1'b0;
        step();
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus0.out_valid || bus1.out_valid) bad = 1'b1;
        end
        check("rm_no_spurious", 32'(bad), 0);
        check("rm_in_ready", 32'(bus0.in_ready), 1);

        // Randomized traffic against the model with a result scoreboard
        pending = 1'b0; rop = '0; ra = '0; rb = '0; rcin = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!pending && ($urandom_range(0, 3) != 0)) begin
                rop = 4'($urandom_range(0, 15));
                ra = 8'($urandom); rb = 8'($urandom); rcin = 1'($urandom);
                pending = 1'b1;
            end
            bus0.in_valid = pending;
            bus0.opcode = rop; bus0.a = ra; bus0.b = rb; bus0.carry_in = rcin;
            bus0.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (bus0.out_valid) begin
                if (q0.size() == 0) check("rnd_spurious", 1, 0);
                else begin
                    check("rnd_dut0", 32'(act(0)), 32'(q0[0]));
                    check("rnd_dut1", 32'(act(1)), 32'(q1[0]));
                    if (bus0.out_ready) begin void'(q0.pop_front()); void'(q1.pop_front()); end
                end
            end
            if (bus0.in_valid && bus0.in_ready) begin
                e0 = model(rop, ra, rb, rcin);
                e1 = model(rop, ra, rb, (rop == OP_ADC) ? mflag1 : rcin);
                if (sets_carry_flag(rop)) mflag1 = e1.fl[0] | e1.fl[1];
                q0.push_back(e0); q1.push_back(e1);
                pending = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
        for (int c = 0; c < 30 && q0.size() > 0; c++) begin
            #1;
            if (bus0.out_valid) begin
                check("drain_dut0", 32'(act(0)), 32'(q0[0]));
                check("drain_dut1", 32'(act(1)), 32'(q1[0]));
                void'(q0.pop_front()); void'(q1.pop_front());
            end
            @(posedge clk); #1;
        end
        check("scoreboard_empty", 32'(q0.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Registered, handshaked successor to the combinational 8-bit ALU, parametrised in width.
- Adds ADD carry-out, OR/XOR, and a multi-cycle shift-add multiply (MUL) with a double-width result.
- Adds an optional internal carry flag for chained multi-word arithmetic.
- Sits between an operand source (valid/ready) and a result sink (valid/ready) in the datapath.

Parameters:
- BUS_WIDTH, 8: operand/result width. Must be at least 2.
- CARRY_FROM_FLAG, 0:
  - 0: ADC uses the carry_in port.
  - 1: ADC uses the internal carry flag register.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand/opcode valid
- in_ready  output  1  block can accept an operation this cycle
- opcode  input  4  operation select
- a  input  BUS_WIDTH  operand A
- b  input  BUS_WIDTH  operand B
- carry_in  input  1  carry for ADC when CARRY_FROM_FLAG=0
- out_valid  output  1  result registers valid
- out_ready  input  1  sink accepts result
- y  output  BUS_WIDTH  result (low word for MUL)
- y_hi  output  BUS_WIDTH  MUL high word; 0 for all other ops
- carry_out  output  1  carry from ADD/ADC/INC
- borrow  output  1  borrow from SUB/DEC
- zero  output  1  {y_hi,y}==0
- parity  output  1  XOR-reduce of {y_hi,y}
- invalid_op  output  1  opcode not defined
- busy  output  1  MUL iteration in progress

Behaviour:
- Opcodes:
  - 1 ADD: {carry_out,y}=a+b
  - 2 ADC: {carry_out,y}=a+b+c
  - 3 SUB: {borrow,y}=a-b
  - 4 INC: {carry_out,y}=a+1
  - 5 DEC: {borrow,y}=a-1
  - 6 AND
  - 7 NOT a
  - 8 ROL a by 1
  - 9 ROR a by 1
  - 10 OR
  - 11 XOR
  - 12 MUL unsigned: {y_hi,y}=a*b
  - 0, 13, 14, 15: invalid. Result has invalid_op=1 and all other outputs 0.
- Flags: unused flags are 0 for every op. y_hi=0 except MUL.
- All arithmetic is done at BUS_WIDTH+1 bits. The MSB is carry_out or borrow.
- Reset (async, rst_n low): every output register is 0, out_valid=0, busy=0, FSM=IDLE, carry flag=0, MUL accumulators=0. in_ready is 1 while in IDLE with out_valid=0.
- Reset mid-MUL aborts the multiply with no output.
- Accept rule: an operation is accepted on an edge where in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This gives full throughput for single-cycle ops.
- FSM states:
  - IDLE
    - Accept of a non-MUL op: compute combinationally and register all outputs. out_valid=1 on the following cycle (latency 1).
    - Accept of MUL: latch a and b, clear the accumulator, set counter=0, go to MUL_RUN, busy=1.
  - MUL_RUN
    - Each cycle: if the multiplier LSB is set, add the multiplicand into the upper accumulator, then shift right. Counter increments.
    - After BUS_WIDTH iterations, register the result and flags, set out_valid=1, go to IDLE, busy=0.
    - MUL accepted at edge k gives out_valid at edge k+BUS_WIDTH+1.
    - in_ready=0 throughout MUL_RUN.
    - MUL_RUN completion while a previous result is still stalled cannot occur, because accept requires the output to be free or consumed.
- Output hold: while out_valid && !out_ready, every output is stable.
- out_valid clears on the edge where out_ready=1, unless a new result is loaded on that same edge (back-to-back: stays 1 with new data).
- Carry flag:
  - Loaded with carry_out on completion of ADD/ADC/INC.
  - Loaded with borrow on completion of SUB/DEC.
  - Unchanged by all other ops, including invalid ops.
  - With CARRY_FROM_FLAG=1, ADC reads the flag value from before the current operation.
- Wrap-around:
  - INC of all-ones gives y=0, carry_out=1, zero=1.
  - DEC of 0 gives y=all-ones, borrow=1.
  - MUL of all-ones × all-ones gives y_hi=all-ones−1, y=1.
- in_valid with in_ready=0: nothing is accepted. The source holds its data; the block need not sample it.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD..OP_MUL (values 1..12)
  - flag bundle field order {invalid_op, parity, zero, borrow, carry_out}
- This package is also adopted by the existing combinational ALU and the testbench model.
- One sub-module: alu_mul_shiftadd, the iterative multiplier. Ports: start, a, b, done, product[2*BUS_WIDTH-1:0]. The top FSM sequences it.

Test Plan:
- ADD a=200, b=100, out_ready=1 → one cycle later y=44, carry_out=1, zero=0, parity=1, out_valid for 1 cycle.
- MUL a=255, b=255 at edge k → busy for 8 cycles, in_ready=0. At edge k+9: y_hi=254, y=1, out_valid=1.
- Back-to-back stream INC 255 then DEC 0, out_ready=1:
  - First result: y=0, carry_out=1, zero=1.
  - Next cycle: y=255, borrow=1, parity=0.
  - in_ready stays 1.
- Backpressure: SUB 5−7 with out_ready=0 for 4 cycles → y=254, borrow=1 held stable, in_ready=0. On out_ready=1, out_valid drops.
- CARRY_FROM_FLAG=1: ADD 255+1 then ADC 0+0 → second result y=1. Opcode 14 → invalid_op=1, y=0, flag unchanged.
- rst_n low at cycle 3 of a MUL → all outputs 0 asynchronously. After release: in_ready=1, no spurious out_valid.
